// File: rtl/mac_36_pkg.sv
// Shared constants, width helpers and the S1 payload layout for the mac_36 pipeline.
package mac_36_pkg;

  localparam int MAC_WIDTH = 4;
  localparam int PROD_W    = 2 * MAC_WIDTH;
  localparam int SUM_W     = 2 * MAC_WIDTH + 1;

  typedef struct packed {
    logic [PROD_W-1:0]    p;
    logic [MAC_WIDTH-1:0] c;
    logic                 acc_mode;
  } s1_payload_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/mac_36_pipe_slice.sv
// Generic valid/ready register slice; ready passes straight through from downstream (no skid).
module mac_36_pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          adv, fire;

  always_comb begin
    adv      = !valid_q || out_ready;
    in_ready = adv && resetb;
    fire     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (fire) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mac_36_pipe.sv
// Two-stage handshaked multiply-accumulate: S1 registers the product, S2 adds c or the accumulator.
module mac_36_pipe
  import mac_36_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             acc_mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf
);

  localparam int PW = prod_w(WIDTH);
  localparam int SW = sum_w(WIDTH);

  typedef struct packed {
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] c;
    logic             acc_mode;
  } s1_t;

  s1_t              s1_in, s1_data;
  logic             s1_valid;
  logic             s2_adv, s2_load;
  logic [WIDTH-1:0] addend;
  logic [SW-1:0]    sum;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    s1_in.p        = PW'(a) * PW'(b);
    s1_in.c        = c;
    s1_in.acc_mode = acc_mode;
  end

  mac_36_pipe_slice #(.DW($bits(s1_t))) u_s1 (
    .clk       (clk),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_adv),
    .out_data  (s1_data)
  );

  // A clear coinciding with a load zeroes the addend, but the stored acc still takes the new sum.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s2_load     = s1_valid && s2_adv;
    addend      = s1_data.acc_mode ? (clear ? '0 : acc_q) : s1_data.c;
    sum         = SW'(s1_data.p) + SW'(addend);
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_d       = sum[WIDTH-1:0];
      ovf_d       = |sum[SW-1:WIDTH];
      acc_d       = sum[WIDTH-1:0];
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (clear) acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_36_pipe.sv
// Directed and randomized bench for mac_36_pipe against an arithmetic result-queue model.
module tb_mac_36_pipe;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         resetb;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c;
  logic         acc_mode;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_ovf;

  int total;
  int bad;
  int q[$];
  int model_acc;
  int ovr;
  bit last_in_fire;
  bit prev_stall;
  logic [W-1:0] prev_out;
  logic         prev_ovf;

  mac_36_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .acc_mode  (acc_mode),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score results, update the model, advance past the edge.
  task automatic tick();
    bit in_fire, out_fire;
    int s, e;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (prev_stall) begin
      check("hold_out", out, prev_out);
      check("hold_ovf", out_ovf, prev_ovf);
    end
    prev_stall = resetb && out_valid && !out_ready;
    prev_out   = out;
    prev_ovf   = out_ovf;
    if (out_fire) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("out", out, e % MOD);
        check("out_ovf", out_ovf, (e >= MOD) ? 1 : 0);
      end
    end
    if (clear) model_acc = 0;
    if (in_fire) begin
      if (ovr >= 0) begin
        s   = ovr;
        ovr = -1;
      end else begin
        s = int'(a) * int'(b) + (acc_mode ? model_acc : int'(c));
      end
      q.push_back(s);
      model_acc = s % MOD;
    end
    last_in_fire = in_fire;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                      input logic tm);
    a = ta; b = tb; c = tc; acc_mode = tm; in_valid = 1'b1;
    last_in_fire = 1'b0;
    for (int i = 0; i < 20 && !last_in_fire; i++) tick();
    check("send_accepted", last_in_fire, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] sa[4], sb[4], sc[4];
    int idx;
    total = 0; bad = 0; model_acc = 0; ovr = -1; prev_stall = 1'b0;
    resetb = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    acc_mode = 1'b0; clear = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_ovf", out_ovf, 0);
    resetb = 1'b1;

    // Single op and its latency
    out_ready = 1'b1;
    send(4'd2, 4'd3, 4'd4, 1'b0);
    check("lat_after_transfer_edge", out_valid, 0);
    @(posedge clk); #1;
    check("lat_next_edge_valid", out_valid, 1);
    check("lat_next_edge_out", out, 10);
    drain();

    // Overflow cases
    send(4'd3, 4'd5, 4'd2, 1'b0);
    send(4'd15, 4'd15, 4'd15, 1'b0);
    drain();

    // Clear, then accumulate
    clear = 1'b1; tick(); clear = 1'b0;
    send(4'd1, 4'd3, 4'd0, 1'b1);
    send(4'd1, 4'd3, 4'd0, 1'b1);
    send(4'd1, 4'd3, 4'd0, 1'b1);
    send(4'd4, 4'd2, 4'd0, 1'b1);
    drain();

    // Stall with four ops queued behind out_ready=0
    for (int i = 0; i < 4; i++) begin
      sa[i] = W'($urandom); sb[i] = W'($urandom); sc[i] = W'($urandom);
    end
    idx = 0;
    acc_mode = 1'b0;
    for (int cyc = 0; cyc < 40 && (idx < 4 || q.size() > 0); cyc++) begin
      out_ready = (cyc >= 3);
      if (idx < 4) begin
        a = sa[idx]; b = sb[idx]; c = sc[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (cyc == 2) begin
        check("stall_accepted", idx, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_first", out, (int'(sa[0]) * int'(sb[0]) + int'(sc[0])) % MOD);
      end
      tick();
      if (last_in_fire) idx++;
    end
    check("stall_all_sent", idx, 4);
    drain();

    // Clear on the same edge as an acc_mode S2 load; acc was 7
    clear = 1'b1; tick(); clear = 1'b0;
    send(4'd7, 4'd1, 4'd0, 1'b1);
    drain();
    ovr = 4;
    send(4'd2, 4'd2, 4'd0, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0;
    model_acc = 4;
    drain();
    send(4'd0, 4'd0, 4'd9, 1'b1);
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(4'd5, 4'd5, 4'd1, 1'b0);
    send(4'd6, 4'd3, 4'd2, 1'b0);
    resetb = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_ovf", out_ovf, 0);
    q.delete();
    model_acc = 0;
    resetb = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("postrst_no_stale", out_valid, 0);
    send(4'd1, 4'd1, 4'd0, 1'b0);
    drain();

    // Randomized traffic; clear only when nothing is in flight
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      c         = W'($urandom);
      acc_mode  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = (q.size() == 0) && ($urandom_range(0, 7) == 0);
      tick();
    end
    clear = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_36_pipe.md
# mac_36_pipe

Registered, handshaked counterpart of the combinational mac_36 benchmark: accepts (a, b, c) operand sets over valid/ready, returns out = a*b + c truncated to WIDTH bits, plus an overflow flag and an optional running-accumulate mode. It sits between a stimulus source and a result checker in the dsp18 benchmark flow, so the fabric can be exercised with a real sequential MAC rather than a pure combinational path.

## Interface
- WIDTH, 4, operand and result width in bits; must be 2..9 so the product fits one DSP18 multiplier.
- clk  in  1  single clock, all logic on rising edge.
- resetb  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- c  in  WIDTH  addend, unsigned; ignored when acc_mode=1.
- acc_mode  in  1  1: addend is the internal accumulator instead of c; travels with the transaction.
- clear  in  1  zero the accumulator (independent of the handshake).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result, (a*b + addend) mod 2^WIDTH.
- out_ovf  out  1  1 if the full-precision sum needed more than WIDTH bits.

## Operation
- Transfer on either side happens only when valid and ready are both 1 on the same rising edge.
- Stage 1 (S1): on input transfer, register p = a*b (2*WIDTH bits), c, acc_mode; set s1_valid.
- Stage 2 (S2): on S1 -> S2 move, compute sum = p + (acc_mode ? acc : c) at 2*WIDTH+1 bits; out <= sum[WIDTH-1:0]; out_ovf <= |sum[2*WIDTH:WIDTH]; out_valid <= 1.
- acc <= sum[WIDTH-1:0] on every S2 load, regardless of acc_mode (acc always holds the last result).
- clear: acc <= 0. Same cycle as an S2 load: if the loading transaction has acc_mode=1 it uses 0 as addend, and acc takes the new sum (load wins over clear for the stored value).
- Stall: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv && resetb.
- Output holds out, out_ovf stable while out_valid && !out_ready.
- Results emerge in input order; no reordering, no dropping while resetb=1.
- Reset (resetb=0 at an edge): s1_valid=0, out_valid=0, out=0, out_ovf=0, acc=0; in-flight transactions discarded; in_ready=0 combinationally while resetb=0.

## Timing
- Latency: input transfer at edge N -> out_valid=1 after edge N+1 (visible in cycle N+1, consumable at edge N+2) when unstalled.
- Throughput: one transaction per cycle with out_ready held high.
- in_ready depends combinationally on out_ready (no skid buffer); max 2 transactions in flight.
- Back-to-back acc_mode transactions accumulate correctly at full rate: S2 reads acc written by the preceding S2 load.
- Reset mid-operation: first edge with resetb=1 after release may accept input; first result 2 edges later.

## Structure
- Package mac_36_pkg: default WIDTH constant, derived widths PROD_W=2*WIDTH, SUM_W=2*WIDTH+1, and a packed S1 payload struct (p, c, acc_mode).
- One sub-module: mac_36_pipe_slice, a generic valid/ready register slice (payload parameterised) instantiated for S1; S2 arithmetic and accumulator stay in the top.
- Product must map to one DSP18 multiplier; no other hard blocks.

## Test plan
- Reset then single op a=2,b=3,c=4,acc_mode=0 -> out=10, out_ovf=0, out_valid exactly 2 edges after transfer.
- a=3,b=5,c=2 -> sum 17 -> out=1, out_ovf=1; a=15,b=15,c=15 -> 240 -> out=0, out_ovf=1.
- clear, then three acc_mode ops a=1,b=3 back-to-back -> out=3,6,9, out_ovf=0; fourth op a=4,b=2 -> 17 -> out=1, out_ovf=1.
- Stream 4 ops with out_ready=0 for cycles 1-3 -> in_ready drops after 2 accepted, out holds first result, all 4 results delivered in order once out_ready=1.
- clear in the same cycle as an acc_mode S2 load with a=2,b=2 (acc previously 7) -> out=4, acc=4 afterwards.
- resetb=0 for one edge with 2 ops in flight -> out_valid=0, out=0, out_ovf=0, no stale results after release; next op a=1,b=1,c=0 -> out=1.
